// File: rtl/ga_pkg.sv
// Constants and state encoding shared by the GA pipeline (population writer, reader, selection).
// Pure declarations: no latency, no flow control.
package ga_pkg;

  localparam int POP_BITS = 1875;
  localparam int IND_BITS = 75;
  localparam int NUM_IND  = 25;
  localparam int IDX_W    = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef logic [POP_BITS-1:0] pop_t;
  typedef logic [IND_BITS-1:0] ind_t;

  function automatic ind_t top_ind(input pop_t p);
    return p[POP_BITS-1 -: IND_BITS];
  endfunction

endpackage

// File: rtl/pop_reader_if.sv
// Population read bus: start/done request side plus the per-individual valid/ready stream.
// slave = the reader; master = whoever starts it and consumes the stream.
interface pop_reader_if;
  import ga_pkg::*;

  logic                start;
  logic [POP_BITS-1:0] population;
  logic [IND_BITS-1:0] ind_data;
  logic [IDX_W-1:0]    ind_index;
  logic                ind_valid;
  logic                ind_ready;
  logic                busy;
  logic                done;

  modport slave (
    input  start, population, ind_ready,
    output ind_data, ind_index, ind_valid, busy, done
  );

  modport master (
    output start, population, ind_ready,
    input  ind_data, ind_index, ind_valid, busy, done
  );

endinterface

// File: rtl/pop_reader.sv
// Latches a packed population on start and streams it out MSB individual first; first valid 2 cycles after start.
// ind_data/ind_index hold while ind_ready is low; done pulses one cycle after the last accepted individual.
module pop_reader
  import ga_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  pop_reader_if.slave  bus
);

  if (POP_BITS != NUM_IND * IND_BITS || IDX_W != $clog2(NUM_IND)) begin : g_bad_params
    $error("pop_reader: inconsistent population parameters");
  end

  state_t              state, state_nxt;
  logic [POP_BITS-1:0] shadow, shadow_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;

  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    idx_nxt    = idx;
    case (state)
      IDLE: begin
        if (bus.start) begin
          shadow_nxt = bus.population;
          idx_nxt    = '0;
          state_nxt  = LOAD;
        end
      end
      LOAD: state_nxt = SEND;
      SEND: begin
        if (bus.ind_ready) begin
          if (idx == IDX_W'(NUM_IND - 1)) begin
            state_nxt = DONE;
          end else begin
            // The next individual is always presented from the top slice of the shadow.
            shadow_nxt = shadow << IND_BITS;
            idx_nxt    = idx + IDX_W'(1);
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      shadow <= '0;
      idx    <= '0;
    end else begin
      state  <= state_nxt;
      shadow <= shadow_nxt;
      idx    <= idx_nxt;
    end
  end

  assign bus.ind_data  = top_ind(shadow);
  assign bus.ind_index = idx;
  assign bus.ind_valid = (state == SEND);
  assign bus.busy      = (state == LOAD) || (state == SEND);
  assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_pop_reader.sv
// Randomized bench for pop_reader against a slice-and-count reference model of the readout.
// Inputs driven 1 time unit after posedge; outputs sampled at the same point.
module tb_pop_reader;
  import ga_pkg::*;

  typedef logic [IND_BITS-1:0] w_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  pop_reader_if bus();

  pop_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input w_t got, input w_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: individual k sits at the k-th IND_BITS slice counted from the MSB end.
  function automatic w_t ind_of(input pop_t p, input int k);
    return p[POP_BITS-1-k*IND_BITS -: IND_BITS];
  endfunction

  function automatic pop_t rand_pop();
    pop_t p;
    for (int i = 0; i < POP_BITS; i++) p[i] = 1'($urandom);
    return p;
  endfunction

  // mode 0: ready always high; 1: ready pattern 1,0,0; 2: random ready.
  // poke_idx >= 0: pulse start with an all-zero population while that index is on the bus.
  task automatic readout(input pop_t p, input int mode, input int poke_idx, input string name);
    int  exp_idx     = 0;
    int  t           = 0;
    int  first_valid = -1;
    int  done_at     = -1;
    bit  finished    = 1'b0;
    bit  poked       = 1'b0;
    bit  exp_valid;
    bus.population = p;
    bus.start      = 1'b1;
    bus.ind_ready  = 1'b0;
    while (!finished && t < 400) begin
      step();
      t++;
      exp_valid = 1'b0;
      if (t == 1) begin
        check({name, "_load_busy"}, w_t'(bus.busy), w_t'(1));
        check({name, "_load_valid"}, w_t'(bus.ind_valid), w_t'(0));
      end else if (exp_idx == NUM_IND) begin
        check({name, "_done"}, w_t'(bus.done), w_t'(1));
        check({name, "_done_valid"}, w_t'(bus.ind_valid), w_t'(0));
        check({name, "_done_busy"}, w_t'(bus.busy), w_t'(0));
        done_at  = t;
        finished = 1'b1;
      end else begin
        exp_valid = 1'b1;
        check({name, "_valid"}, w_t'(bus.ind_valid), w_t'(1));
        check({name, "_nodone"}, w_t'(bus.done), w_t'(0));
        if (first_valid < 0) first_valid = t;
        check({name, "_index"}, w_t'(bus.ind_index), w_t'(exp_idx));
        check({name, "_data"}, bus.ind_data, ind_of(p, exp_idx));
      end
      bus.start = 1'b0;
      if (poke_idx >= 0 && exp_valid && exp_idx == poke_idx && !poked) begin
        bus.start      = 1'b1;
        bus.population = '0;
        poked          = 1'b1;
      end
      case (mode)
        0:       bus.ind_ready = 1'b1;
        1:       bus.ind_ready = ((t - 2) % 3 == 0);
        default: bus.ind_ready = 1'($urandom_range(0, 1));
      endcase
      if (exp_valid && bus.ind_ready) exp_idx++;
    end
    check({name, "_finished"}, w_t'(finished), w_t'(1));
    bus.ind_ready = 1'b0;
    step();
    check({name, "_post_done"}, w_t'(bus.done), w_t'(0));
    check({name, "_post_busy"}, w_t'(bus.busy), w_t'(0));
    check({name, "_post_valid"}, w_t'(bus.ind_valid), w_t'(0));
    if (mode == 0) begin
      check({name, "_first_valid_cycle"}, w_t'(first_valid), w_t'(2));
      check({name, "_done_cycle"}, w_t'(done_at), w_t'(2 + NUM_IND));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pop_t p;
    bit   saw_done;
    int   a, r;

    // Reset
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.ind_ready  = 1'b0;
    bus.population = '0;
    repeat (3) step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_valid", w_t'(bus.ind_valid), w_t'(0));
      check("rst_done", w_t'(bus.done), w_t'(0));
      check("rst_busy", w_t'(bus.busy), w_t'(0));
      check("rst_index", w_t'(bus.ind_index), w_t'(0));
    end
    check("rst_data", bus.ind_data, w_t'(0));

    // Full readout with a recognisable pattern: 1, k in the low byte, all ones at the end
    p = '0;
    for (int k = 0; k < NUM_IND; k++) p[POP_BITS-1-k*IND_BITS -: IND_BITS] = w_t'(k);
    p[POP_BITS-1 -: IND_BITS] = w_t'(1);
    p[IND_BITS-1:0]           = '1;
    readout(p, 0, -1, "full");

    // Backpressure and random readiness
    readout(rand_pop(), 1, -1, "bp");
    readout(rand_pop(), 2, -1, "rnd");

    // Start pulse and population change mid-stream are ignored
    readout(rand_pop(), 0, 10, "ign");

    // Reset mid-stream at index 12
    p              = rand_pop();
    bus.population = p;
    bus.start      = 1'b1;
    bus.ind_ready  = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (13) step();
    check("mid_index", w_t'(bus.ind_index), w_t'(12));
    check("mid_data", bus.ind_data, ind_of(p, 12));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_valid", w_t'(bus.ind_valid), w_t'(0));
    check("abort_busy", w_t'(bus.busy), w_t'(0));
    check("abort_index", w_t'(bus.ind_index), w_t'(0));
    saw_done = bus.done;
    for (int i = 0; i < 30; i++) begin
      step();
      saw_done |= bus.done;
    end
    check("abort_no_done", w_t'(saw_done), w_t'(0));
    readout(rand_pop(), 2, -1, "after_abort");

    // start held high for 60 cycles: readouts accepted at relative cycles 0, 28, 56
    p              = rand_pop();
    bus.population = p;
    bus.start      = 1'b1;
    bus.ind_ready  = 1'b1;
    for (int t = 1; t <= 90; t++) begin
      step();
      if (t == 60) bus.start = 1'b0;
      a = ((t - 1) / 28) * 28;
      if (a > 56) a = 56;
      r = t - a;
      check("b2b_valid", w_t'(bus.ind_valid), w_t'(r >= 2 && r <= 26));
      check("b2b_done", w_t'(bus.done), w_t'(r == 27));
      check("b2b_busy", w_t'(bus.busy), w_t'(r >= 1 && r <= 26));
      if (r >= 2 && r <= 26) begin
        check("b2b_index", w_t'(bus.ind_index), w_t'(r - 2));
        check("b2b_data", bus.ind_data, ind_of(p, r - 2));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
